// File: rtl/fft_stage_seq.sv
// rtl/fft_stage_seq.sv - radix-2 FFT pass sequencer: stage stepping, butterfly issue, bank select
module fft_stage_seq #(
    parameter int N_LOG2  = 4,
    parameter int STAGE_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               hold,
    input  logic               map_dv,
    output logic               map_start,
    output logic [STAGE_W-1:0] stage,
    output logic [N_LOG2-2:0]  bf_idx,
    output logic               bf_valid,
    output logic               bank_sel,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_DRAIN,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(N_LOG2 - 1);

    state_t              state_q, state_d;
    logic [STAGE_W-1:0]  stage_d;
    logic [N_LOG2-2:0]   bf_idx_d;
    logic                bf_valid_d;
    logic                bank_sel_d;
    logic                dv_seen_q, dv_seen_d;

    // Next-state and next-output decode; every output is registered from these values
    always_comb begin
        state_d    = state_q;
        stage_d    = stage;
        bf_idx_d   = bf_idx;
        bf_valid_d = 1'b0;
        bank_sel_d = bank_sel;
        dv_seen_d  = dv_seen_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LAUNCH;
                    stage_d    = '0;
                    bank_sel_d = 1'b0;
                end
            end
            S_LAUNCH: begin
                // index 0 is presented on entry to RUN
                state_d    = S_RUN;
                bf_idx_d   = '0;
                bf_valid_d = 1'b1;
            end
            S_RUN: begin
                // an early map_dv is remembered so DRAIN can leave after one cycle
                dv_seen_d = dv_seen_q | map_dv;
                if (!hold) begin
                    if (&bf_idx) begin
                        state_d = S_DRAIN;
                    end else begin
                        bf_idx_d   = bf_idx + 1'b1;
                        bf_valid_d = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                dv_seen_d = dv_seen_q | map_dv;
                if (map_dv || dv_seen_q) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (stage == LAST_STAGE) begin
                    state_d = S_DONE;
                end else begin
                    state_d    = S_LAUNCH;
                    stage_d    = stage + 1'b1;
                    bank_sel_d = ~bank_sel;
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                stage_d    = '0;
                bank_sel_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // each stage starts with a fresh index and no remembered data-valid
        if (state_d == S_LAUNCH) begin
            bf_idx_d  = '0;
            dv_seen_d = 1'b0;
        end
    end

    // State and registered outputs; reset aborts any transform without a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            stage     <= '0;
            bf_idx    <= '0;
            bf_valid  <= 1'b0;
            bank_sel  <= 1'b0;
            dv_seen_q <= 1'b0;
            map_start <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            stage     <= stage_d;
            bf_idx    <= bf_idx_d;
            bf_valid  <= bf_valid_d;
            bank_sel  <= bank_sel_d;
            dv_seen_q <= dv_seen_d;
            map_start <= (state_d == S_LAUNCH);
            busy      <= (state_d != S_IDLE);
            done      <= (state_d == S_DONE);
        end
    end

endmodule

// File: tb/tb_fft_stage_seq.sv
// tb/tb_fft_stage_seq.sv - scoreboard bench for fft_stage_seq
module tb_fft_stage_seq;
    localparam int N_LOG2  = 4;
    localparam int STAGE_W = 2;
    localparam int NBF     = 1 << (N_LOG2 - 1);

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               hold = 1'b0;
    logic               map_dv = 1'b0;
    logic               map_start;
    logic [STAGE_W-1:0] stage;
    logic [N_LOG2-2:0]  bf_idx;
    logic               bf_valid;
    logic               bank_sel;
    logic               busy;
    logic               done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int exp_launch[$];
    int exp_bf[$];
    int exp_done = 0;
    int ms_log[$];
    int done_log[$];
    int fall_log[$];
    bit prev_busy = 1'b0;

    fft_stage_seq #(.N_LOG2(N_LOG2), .STAGE_W(STAGE_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .map_dv(map_dv),
        .map_start(map_start), .stage(stage), .bf_idx(bf_idx), .bf_valid(bf_valid),
        .bank_sel(bank_sel), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference model: a transform is N_LOG2 stages, each a launch followed by
    // every butterfly index once in order, read bank alternating from 0; then one done.
    task automatic push_transform();
        for (int s = 0; s < N_LOG2; s++) begin
            exp_launch.push_back(s * 2 + s % 2);
            for (int i = 0; i < NBF; i++) exp_bf.push_back(s * 256 + i * 2 + s % 2);
        end
        exp_done++;
    endtask

    task automatic clear_logs();
        ms_log.delete();
        done_log.delete();
        fall_log.delete();
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a launch, an index or done
    always @(negedge clk) begin
        if (rst_n) begin
            if (map_start) begin
                ms_log.push_back(cyc);
                if (exp_launch.size() == 0) fail_evt("spurious map_start");
                else check("launch stage/bank", int'(stage) * 2 + int'(bank_sel), exp_launch.pop_front());
            end
            if (bf_valid) begin
                if (exp_bf.size() == 0) fail_evt("spurious bf_valid");
                else check("bf stage/idx/bank", int'(stage) * 256 + int'(bf_idx) * 2 + int'(bank_sel),
                           exp_bf.pop_front());
            end
            if (done) begin
                done_log.push_back(cyc);
                if (exp_done == 0) fail_evt("spurious done");
                else begin
                    exp_done--;
                    check("done stage", int'(stage), N_LOG2 - 1);
                    check("done busy", int'(busy), 1);
                end
            end
            if (prev_busy && !busy) fall_log.push_back(cyc);
            prev_busy = busy;
        end else begin
            prev_busy = 1'b0;
        end
    end

    // One directed transform; inputs react to presented outputs (final RUN cycle gets map_dv)
    task automatic run_dir(input int late_stage, input bit stall, input bit s5, input int ncyc,
                           output int te);
        int late_cnt   = 0;
        int stall_left = 0;
        int restart    = 0;
        bit stall_done = 1'b0;
        bit mid_done   = 1'b0;
        clear_logs();
        @(negedge clk);
        start = 1'b1;
        push_transform();
        @(negedge clk);
        te = cyc;
        for (int r = 0; r < ncyc; r++) begin
            hold = 1'b0;
            map_dv = 1'b0;
            start = 1'b0;
            if (stall_left > 0) begin
                hold = 1'b1;
                stall_left--;
            end else if (stall && !stall_done && bf_valid && bf_idx == 3'd4 && stage == 2'd0) begin
                hold = 1'b1;
                stall_left = 2;
                stall_done = 1'b1;
            end
            if (late_cnt > 0) begin
                late_cnt--;
                if (late_cnt == 0) map_dv = 1'b1;
            end else if (bf_valid && int'(bf_idx) == NBF - 1) begin
                if (int'(stage) == late_stage) late_cnt = 6;
                else map_dv = 1'b1;
            end
            if (s5) begin
                if (!mid_done && stage == 2'd2 && bf_valid && bf_idx == 3'd3) begin
                    start = 1'b1;
                    mid_done = 1'b1;
                end
                if (restart == 1) begin
                    start = 1'b1;
                    restart = 2;
                    push_transform();
                end
                if (done && restart == 0) begin
                    start = 1'b1;
                    restart = 1;
                end
            end
            @(negedge clk);
        end
        hold = 1'b0;
        map_dv = 1'b0;
        start = 1'b0;
    endtask

    task automatic check_launches(input string name, input int te, input int want[$]);
        check({name, " launch count"}, ms_log.size(), want.size());
        foreach (want[k]) if (k < ms_log.size()) check({name, " launch time"}, ms_log[k] - te, want[k]);
    endtask

    task automatic check_end(input string name, input int te, input int d_rel, input int f_rel);
        check({name, " done count"}, done_log.size(), 1);
        if (done_log.size() > 0) check({name, " done time"}, done_log[0] - te, d_rel);
        if (fall_log.size() > 0) check({name, " busy fall time"}, fall_log[0] - te, f_rel);
        else fail_evt({name, " busy never fell"});
    endtask

    initial begin
        int te;
        int busy_cnt;
        int d0;
        int budget;

        // Scenario 1: reset, then idle with start low
        repeat (3) @(negedge clk);
        check("outputs in reset", int'({map_start, stage, bf_idx, bf_valid, bank_sel, busy, done}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("outputs after reset", int'({map_start, stage, bf_idx, bf_valid, bank_sel, busy, done}), 0);
        busy_cnt = 0;
        clear_logs();
        repeat (20) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        check("idle busy cycles", busy_cnt, 0);
        check("idle map_start pulses", ms_log.size(), 0);

        // Scenario 2: nominal
        run_dir(-1, 1'b0, 1'b0, 50, te);
        check_launches("nominal", te, '{0, 11, 22, 33});
        check_end("nominal", te, 44, 45);

        // Scenario 3: late map_dv in stage 1
        run_dir(1, 1'b0, 1'b0, 56, te);
        check_launches("late dv", te, '{0, 11, 27, 38});
        check_end("late dv", te, 49, 50);

        // Scenario 4: three-cycle stall at index 4 of stage 0
        run_dir(-1, 1'b1, 1'b0, 54, te);
        check_launches("stall", te, '{0, 14, 25, 36});
        check_end("stall", te, 47, 48);

        // Scenario 5: ignored starts, then start held across done restarts once
        run_dir(-1, 1'b0, 1'b1, 95, te);
        check_launches("restart", te, '{0, 11, 22, 33, 46, 57, 68, 79});
        check("restart done count", done_log.size(), 2);
        if (done_log.size() == 2) begin
            check("restart done time 0", done_log[0] - te, 44);
            check("restart done time 1", done_log[1] - te, 90);
        end

        // Scenario 6: asynchronous reset mid-RUN of stage 2
        clear_logs();
        @(negedge clk);
        start = 1'b1;
        push_transform();
        @(negedge clk);
        start = 1'b0;
        budget = 0;
        while (!(stage == 2'd2 && bf_valid && bf_idx == 3'd3) && budget < 60) begin
            map_dv = bf_valid && int'(bf_idx) == NBF - 1;
            @(negedge clk);
            budget++;
        end
        map_dv = 1'b0;
        if (budget >= 60) fail_evt("stage 2 never reached");
        #2 rst_n = 1'b0;
        #1;
        check("async reset outputs", int'({map_start, stage, bf_idx, bf_valid, bank_sel, busy, done}), 0);
        exp_launch.delete();
        exp_bf.delete();
        exp_done = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("aborted done count", done_log.size(), 0);
        run_dir(-1, 1'b0, 1'b0, 50, te);
        check_launches("after abort", te, '{0, 11, 22, 33});
        check_end("after abort", te, 44, 45);

        // Randomized hold, map_dv and ignored starts against the model
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            start = 1'b1;
            push_transform();
            @(negedge clk);
            start = 1'b0;
            d0 = done_log.size();
            budget = 0;
            while (budget < 600) begin
                hold   = ($urandom_range(0, 3) == 0);
                map_dv = ($urandom_range(0, 4) == 0);
                start  = busy && ($urandom_range(0, 7) == 0);
                @(negedge clk);
                budget++;
                if (done_log.size() > d0 && !busy) break;
            end
            start = 1'b0;
            hold = 1'b0;
            map_dv = 1'b0;
            if (budget >= 600) fail_evt("random transform timeout");
        end

        check("leftover launches", exp_launch.size(), 0);
        check("leftover indices", exp_bf.size(), 0);
        check("leftover done", exp_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fft_stage_seq.md
Name: fft_stage_seq

Overview:
Top-level sequencer for one radix-2 FFT pass. It steps the stage counter through all log2(N) stages. For each stage it:
- launches the coefficient mapper with a one-cycle start pulse,
- issues one butterfly index per cycle into the butterfly datapath,
- waits for the mapper's data-valid before moving to the next stage.

It also drives the ping-pong memory bank select. It reports busy while running and pulses done when the transform is complete.

Parameters:
N_LOG2, 4, log2 of FFT length; stages = N_LOG2, butterflies per stage = 2^(N_LOG2-1)
STAGE_W, 2, width of stage output; must satisfy 2^STAGE_W >= N_LOG2

Ports:
clk  in  1  system clock, all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  transform request; sampled only in IDLE
hold  in  1  datapath stall; freezes butterfly issue while high
map_dv  in  1  mapper data-valid; marks the end of the current stage's coefficient stream
map_start  out  1  one-cycle launch pulse to coefficient mapper
stage  out  STAGE_W  current stage index, stable for the whole stage
bf_idx  out  N_LOG2-1  butterfly index within the stage
bf_valid  out  1  bf_idx is valid this cycle
bank_sel  out  1  ping-pong read bank; write bank is ~bank_sel
busy  out  1  high from the LAUNCH of stage 0 through DONE
done  out  1  one-cycle completion pulse

Behaviour:
- All outputs registered (Moore).
- Reset (asynchronous, any state): state=IDLE; map_start=0; stage=0; bf_idx=0; bf_valid=0; bank_sel=0; busy=0; done=0; dv_seen=0.
- IDLE:
  - busy=0.
  - If start=1 on an edge: go to LAUNCH with stage=0, bank_sel=0.
- LAUNCH (1 cycle):
  - map_start=1, busy=1, bf_idx=0, dv_seen cleared.
  - Next state: RUN.
- RUN:
  - bf_valid = ~hold.
  - On an edge with hold=0: bf_idx increments.
  - On an edge with hold=1: bf_idx and bf_valid freeze low/held; no index is skipped or repeated.
  - After the edge that consumes index 2^(N_LOG2-1)-1: go to DRAIN, bf_valid=0.
- DRAIN:
  - Wait until (map_dv | dv_seen), then go to NEXT.
  - If map_dv is already latched, DRAIN lasts exactly 1 cycle.
  - No timeout.
- dv_seen flag:
  - Set by map_dv=1 in any of RUN or DRAIN.
  - An early map_dv is therefore never lost.
  - map_dv in IDLE, LAUNCH, NEXT or DONE is ignored.
- NEXT (1 cycle):
  - If stage == N_LOG2-1: go to DONE.
  - Otherwise: stage+1, bank_sel toggles, go to LAUNCH.
- DONE (1 cycle):
  - done=1, busy=1.
  - Next state: IDLE; stage returns to 0 and bank_sel to 0 on that edge.
- start while not in IDLE is ignored; no queueing.
- start held high continuously restarts a new transform from IDLE one cycle after each DONE.
- Timing with hold=0 and map_dv latched before DRAIN (edge 0 = edge sampling start):
  - Each stage takes 11 cycles: LAUNCH 1, RUN 8 (for N_LOG2=4), DRAIN 1, NEXT 1.
  - stage k LAUNCH follows edge 11k.
  - done follows edge 11*N_LOG2 (= 44).
  - busy falls after edge 45.
- bf_idx wraps naturally at its width; the RUN exit is decoded from its all-ones value with hold=0.
- Reset mid-transform aborts immediately.
  - No done pulse is issued.
  - A later start begins at stage 0.

Test Plan:
1. Reset then idle: hold rst_n=0 for 3 cycles, release → all outputs 0; with start=0 for 20 cycles, busy stays 0 and map_start never pulses.
2. Nominal run (N_LOG2=4, hold=0, map_dv pulsed 1 cycle each stage during the final RUN cycle):
   - map_start high after edges 0, 11, 22, 33;
   - stage = 0,1,2,3 and bank_sel = 0,1,0,1 in those stages;
   - bf_idx steps 0..7 with bf_valid=1 for 8 cycles per stage;
   - done=1 exactly once after edge 44.
3. Late dv: map_dv arrives 5 cycles after DRAIN entry in stage 1 → DRAIN lasts 6 cycles; stage stays 1; bf_valid=0 throughout; done delayed by 5 cycles to after edge 49.
4. Stall: hold=1 for 3 cycles while bf_idx=4 in stage 0 → bf_valid=0 for those 3 cycles; bf_idx then resumes at 4 and reaches 7; 8 valid indices total; stage 0 lasts 14 cycles.
5. start asserted during stage 2 and during DONE → ignored; exactly one done pulse; start pulsed one cycle after done → a new LAUNCH with stage=0.
6. Reset asserted asynchronously mid-RUN of stage 2 → outputs 0 immediately, before the next clock edge; no done pulse; a subsequent start reproduces the scenario 2 timing.
